// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential BCD-to-binary converter.
//   state_e        : converter FSM state encoding (IDLE / SHIFT / DONE)
//   BCD_ADJ_THRESH : digit value at or above which a correction is applied
//   BCD_ADJ_SUB    : correction subtracted from a digit after each shift
//   BCD_MAX_DIGIT  : largest legal decimal digit value
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational per-digit correction for reverse double dabble: a digit that
// has just received a bit shifted in from its upper neighbour is worth 8 or
// more only because that bit carried a decimal weight of 10 instead of the
// binary weight of 16, so 3 is subtracted to restore a correct BCD digit.
// Ports:
//   digit_i : 4-bit digit after the shift
//   digit_o : corrected digit (digit_i - 3 when digit_i >= 8, else digit_i)
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i - BCD_ADJ_SUB) : digit_i;

endmodule : bcd_digit_adj

// File: rtl/bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq
// Sequential packed-BCD to binary converter using reverse double dabble.
// One bit of the result is produced per SHIFT cycle, so a conversion takes
// BW SHIFT cycles followed by one DONE cycle in which the result is flagged.
//
// Parameters:
//   NDIG : number of packed BCD digits on bcd (digit 0 in bits [3:0])
//   BW   : binary result width, must satisfy 2^BW > 10^NDIG - 1
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   start : conversion request, only looked at while idle
//   bcd   : packed BCD operand, captured when start is accepted
//   busy  : high during SHIFT and DONE
//   done  : one-cycle pulse; bin and err are valid in that cycle
//   bin   : binary result, held until the next done
//   err   : invalid-digit flag, qualified by done
//
// Build option:
//   BCD2BIN_DIGIT_CHECK_EN : when defined, a captured operand containing any
//   digit above 9 finishes with err=1 and bin=0. When undefined, err stays 0
//   and such operands produce a deterministic but meaningless bin. Latency is
//   the same in both builds.
// ---------------------------------------------------------------------------
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int BW   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd,
    output logic                busy,
    output logic                done,
    output logic [BW-1:0]       bin,
    output logic                err
);

    localparam int WW    = 4 * NDIG;
    localparam int CNT_W = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BW - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [WW-1:0]     work_q;      // remaining BCD digits being drained
    logic [BW-1:0]     part_q;      // binary result, filled from the MSB
    logic [CNT_W-1:0]  cnt_q;       // shift index 0..BW-1
    logic              inv_q;       // captured operand had an illegal digit
    logic              busy_q;
    logic              done_q;
    logic [BW-1:0]     bin_q;
    logic              err_q;

    // ------------------------------------------------------------------
    // Datapath: one right shift of {work, partial}, then digit correction
    // ------------------------------------------------------------------
    logic [WW+BW-1:0]  shifted;
    logic [WW-1:0]     work_shift;
    logic [WW-1:0]     work_adj;
    logic [WW-1:0]     work_d;
    logic [BW-1:0]     part_d;
    logic              last_shift;

    assign shifted    = {work_q, part_q} >> 1;
    assign work_shift = shifted[WW+BW-1:BW];
    assign part_d     = shifted[BW-1:0];
    assign last_shift = (cnt_q == CNT_LAST);

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (work_shift[4*g +: 4]),
            .digit_o (work_adj[4*g +: 4])
        );
    end

    // The correction is skipped after the final shift: the work register is
    // no longer consumed, and leaving it untouched keeps the last step a
    // pure shift.
    assign work_d = last_shift ? work_shift : work_adj;

    // ------------------------------------------------------------------
    // Operand legality, evaluated on the incoming bcd at capture time
    // ------------------------------------------------------------------
    logic capture_bad;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic digit_bad;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] > BCD_MAX_DIGIT) begin
                digit_bad = 1'b1;
            end
        end
    end

    assign capture_bad = digit_bad;
`else
    assign capture_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of the
    // order of statements in this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_q  <= bcd;
                        part_q  <= '0;
                        cnt_q   <= '0;
                        inv_q   <= capture_bad;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    work_q <= work_d;
                    part_q <= part_d;
                    if (last_shift) begin
                        // part_d already holds the complete result here, so
                        // bin is loaded on the same edge that enters DONE.
                        bin_q   <= inv_q ? '0 : part_d;
                        err_q   <= inv_q;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bin  = bin_q;
    assign err  = err_q;

endmodule : bcd2bin_seq

// File: tb/tb_bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd2bin_seq
// Self-checking bench for bcd2bin_seq with default parameters (NDIG=3,
// BW=10). Directed table of operands with hand-computed results, followed by
// hand-written sequences for held start, mid-conversion reset, ignored start
// while busy, and a full 000..999 sweep against a decimal reference.
// Latency is counted in rising edges including the edge that samples start,
// so a conversion reports done after edge 11.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bcd2bin_seq;

    localparam int NDIG    = 3;
    localparam int BW      = 10;
    localparam int LATENCY = BW + 1;
    localparam int SPACING = BW + 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [4*NDIG-1:0] bcd;
    logic              busy;
    logic              done;
    logic [BW-1:0]     bin;
    logic              err;

    int checks   = 0;
    int failures = 0;
    int overlap_errs = 0;

    bcd2bin_seq #(.NDIG(NDIG), .BW(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done must never appear without busy
    always @(negedge clk) begin
        if (rst_n && done && !busy) overlap_errs++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    // Wait for idle, request one conversion, then wait (bounded) for done.
    // lat counts rising edges from the sampling edge (=1) to the done edge.
    task automatic run_conv(input logic [11:0] v, output logic [BW-1:0] b,
                            output logic e, output int lat, output bit ok);
        int w;
        w = 0;
        while (busy && w < 3 * SPACING) begin
            @(posedge clk); #1;
            w++;
        end
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        ok  = 1'b0;
        while (!ok && lat < 3 * SPACING) begin
            if (done) begin
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        b = bin;
        e = err;
    endtask

    typedef struct {
        logic [11:0]   bcd;
        logic [BW-1:0] bin;
        logic          err;
        bit            chk_bin;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [BW-1:0] b;
        logic          e;
        int            lat;
        bit            ok;
        int            done_cnt;
        int            sweep_bad;
        logic [BW-1:0] held;

        vecs[0] = '{12'h999, 10'd999, 1'b0, 1'b1};
        vecs[1] = '{12'h000, 10'd0,   1'b0, 1'b1};
        vecs[2] = '{12'h010, 10'd10,  1'b0, 1'b1};
        vecs[3] = '{12'h255, 10'd255, 1'b0, 1'b1};
        vecs[4] = '{12'h042, 10'd42,  1'b0, 1'b1};
        vecs[5] = '{12'h500, 10'd500, 1'b0, 1'b1};
        vecs[6] = '{12'h909, 10'd909, 1'b0, 1'b1};
        vecs[7] = '{12'h001, 10'd1,   1'b0, 1'b1};
`ifdef BCD2BIN_DIGIT_CHECK_EN
        vecs[8] = '{12'h1A5, 10'd0,   1'b1, 1'b1};
`else
        vecs[8] = '{12'h1A5, 10'd0,   1'b0, 1'b0};
`endif

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        start = 1'b0;
        bcd   = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_bin",  bin,  0);
        check("reset_err",  err,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].bcd, b, e, lat, ok);
            check($sformatf("vec%0d_done_seen", i), ok, 1);
            check($sformatf("vec%0d_latency", i), lat, LATENCY);
            if (vecs[i].chk_bin) check($sformatf("vec%0d_bin", i), b, vecs[i].bin);
            check($sformatf("vec%0d_err", i), e, vecs[i].err);
        end

        // bin holds its value after done
        run_conv(12'h321, b, e, lat, ok);
        repeat (4) @(posedge clk);
        #1;
        held = bin;
        check("bin_held_after_done", held, 321);
        check("idle_after_done", busy, 0);

        // ---------------- start while busy ignored ----------------
        @(negedge clk);
        bcd = 12'h654; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bcd = 12'h111; start = 1'b1;        // pulse mid-conversion
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 3 * SPACING) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_start_latency", lat, LATENCY);
        check("busy_start_bin", bin, 654);
        repeat (3) @(posedge clk);
        #1;
        check("busy_start_no_retrigger", busy, 0);

        // ---------------- start held high ----------------
        @(negedge clk);
        bcd = 12'h123; start = 1'b1;
        done_cnt = 0;
        for (int t = 1; t <= 36; t++) begin
            @(posedge clk); #1;
            if (t == 5)  bcd = 12'h456;     // must not affect conversion 1
            if (t == 9)  bcd = 12'h123;
            check($sformatf("held_done_t%0d", t), done,
                  (t == 11 || t == 23 || t == 35) ? 1 : 0);
            if (done) begin
                done_cnt++;
                check($sformatf("held_bin_t%0d", t), bin, 123);
            end
            if (t == 35) start = 1'b0;
        end
        check("held_done_count", done_cnt, 3);

        // ---------------- reset mid-conversion ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        bcd = 12'h777; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_bin",  bin,  0);
        check("midrst_err",  err,  0);
        done_cnt = 0;
        repeat (SPACING) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        // start accepted on the first rising edge after release
        @(negedge clk);
        rst_n = 1'b1;
        bcd = 12'h042; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("postrst_first_edge_accept", busy, 1);
        lat = 1;
        while (!done && lat < 3 * SPACING) begin
            @(posedge clk); #1;
            lat++;
        end
        check("postrst_latency", lat, LATENCY);
        check("postrst_bin", bin, 42);

        // ---------------- exhaustive sweep ----------------
        sweep_bad = 0;
        for (int v = 0; v < 1000; v++) begin
            run_conv(to_bcd(v), b, e, lat, ok);
            checks++;
            if (!ok || b !== BW'(v) || e !== 1'b0 || lat != LATENCY) begin
                failures++;
                sweep_bad++;
                if (sweep_bad <= 10)
                    $display("FAIL sweep_%0d actual=%0d err=%0d lat=%0d required=%0d err=0 lat=%0d",
                             v, b, e, lat, v, LATENCY);
            end
        end

        repeat (2) @(posedge clk);
        check("done_without_busy", overlap_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bcd2bin_seq

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 The block SHALL have parameter NDIG, default 3: number of packed BCD input digits.
REQ-002 The block SHALL have parameter BW, default 10: binary result width; 2^BW > 10^NDIG-1 is required.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 The block SHALL have port bcd  input  4*NDIG  packed BCD, digit 0 in bits [3:0], captured on the accepted start edge.
REQ-007 The block SHALL have port busy  output  1  high while a conversion is in progress, SHIFT or DONE.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse; bin and err valid in that cycle.
REQ-009 The block SHALL have port bin  output  BW  binary result, held stable until the next done.
REQ-010 The block SHALL have port err  output  1  invalid-digit flag, qualified by done.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE; transitions: IDLE->SHIFT on start; SHIFT->DONE after BW shift cycles; DONE->IDLE unconditionally.
REQ-012 On the accepted start edge the block SHALL load bcd into the working register, clear the partial result and clear the shift counter.
REQ-013 Each SHIFT cycle SHALL shift {work, partial} right by one; the work LSB enters the partial MSB.
REQ-014 After each shift except the last, every 4-bit work digit >= 8 SHALL have 3 subtracted (reverse double dabble) in the same cycle.
REQ-015 The shift counter SHALL count 0..BW-1; SHIFT SHALL exit when the counter equals BW-1, with no wrap beyond.
REQ-016 On the SHIFT->DONE edge, bin SHALL update to the partial result and err SHALL update.
REQ-017 done SHALL be high exactly in the DONE cycle, BW+1 rising edges after the start-sampling edge (11 for the defaults).
REQ-018 start asserted while busy=1 SHALL be ignored without side effects; start held high in IDLE SHALL begin a new conversion each time IDLE is re-entered.
REQ-019 Changes on bcd after capture SHALL NOT affect the conversion in progress.
REQ-020 The minimum start-to-start spacing SHALL be BW+2 cycles.

Reset
REQ-021 When rst_n=0 the block SHALL immediately enter IDLE, with busy=0, done=0, bin=0, err=0, and the counter and work registers cleared.
REQ-022 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; bin SHALL read 0 afterwards.
REQ-023 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-024 With macro BCD2BIN_DIGIT_CHECK_EN defined, the block SHALL check every digit of the captured bcd; if any digit is > 9, then at done err=1 and bin=0.
REQ-025 Without BCD2BIN_DIGIT_CHECK_EN, err SHALL be constant 0, and the bin value for invalid digits is unspecified but deterministic; latency is identical in both builds.

Structure
REQ-026 Package bcd_pkg SHALL hold the FSM state enum type and the constants BCD_ADJ_THRESH=8 and BCD_ADJ_SUB=3.
REQ-027 A combinational sub-module bcd_digit_adj (4-bit in, 4-bit out, subtract 3 when >= 8) SHALL be instantiated once per digit.

Verification
REQ-028 The bench SHALL cover: bcd=12'h999, start pulse -> done after 11 cycles, bin=999, err=0.
REQ-029 The bench SHALL cover: bcd=12'h000 -> bin=0; bcd=12'h010 -> bin=10; bcd=12'h255 -> bin=255; each within 11 cycles.
REQ-030 The bench SHALL cover: start held high continuously with bcd=12'h123 -> done every 12 cycles, bin=123, and a mid-conversion change of bcd to 12'h456 is ignored.
REQ-031 The bench SHALL cover: rst_n pulsed low at shift cycle 5 of bcd=12'h777 -> no done, bin=0, busy=0 immediately; the next start with 12'h042 gives bin=42.
REQ-032 The bench SHALL cover: bcd=12'h1A5 with BCD2BIN_DIGIT_CHECK_EN -> err=1, bin=0; without the macro -> err=0.
REQ-033 The bench SHALL cover: exhaustive 000..999 sweep compared against a reference model -> zero mismatches, and done is never asserted together with busy=0.
